// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the seven-segment debug display: widths and the
// active-high {g,f,e,d,c,b,a} patterns for each hex digit.
package seg7_scan_display_pkg;

    localparam int unsigned SEG_WIDTH = 7;
    localparam int unsigned DIGITS    = 8;

    localparam logic [SEG_WIDTH-1:0] SEG_HEX_0 = 7'h3F;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_1 = 7'h06;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_2 = 7'h5B;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_3 = 7'h4F;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_4 = 7'h66;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_5 = 7'h6D;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_6 = 7'h7D;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_7 = 7'h07;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_9 = 7'h6F;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_B = 7'h7C;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_C = 7'h39;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_D = 7'h5E;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_E = 7'h79;
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to seven-segment decoder, active-high segments.
module hex7seg_decode
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0]           nibble_i,
    output logic [SEG_WIDTH-1:0] seg_o
);

    always_comb begin
        seg_o = '0;
        unique case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            4'hF: seg_o = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Holds a 32-bit debug value and scans it as 8 hex digits onto a multiplexed
// seven-segment display, with leading-zero blanking, freeze and decimal points.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          value,
    input  logic                 load,
    input  logic                 freeze,
    input  logic                 blank_lz,
    input  logic [DIGITS-1:0]    dp_mask,
    output logic [SEG_WIDTH-1:0] seg,
    output logic                 dp,
    output logic [DIGITS-1:0]    an,
    output logic [31:0]          shown
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);

    logic [31:0]          shown_q, shown_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [SEG_WIDTH-1:0] seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [DIGITS-1:0]    an_q, an_d;

    logic [3:0]           nibble;
    logic [SEG_WIDTH-1:0] dec_seg;
    logic [31:0]          upper;
    logic                 lz_blank;
    logic                 div_wrap;

    assign nibble = shown_q[{idx_q, 2'b00} +: 4];

    hex7seg_decode u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    always_comb begin
        shown_d = (load && !freeze) ? value : shown_q;

        div_wrap = (div_q == DivW'(SCAN_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Blank a digit when it and every digit above it are zero; digit 0 always shows.
        upper    = shown_q >> {idx_q, 2'b00};
        lz_blank = blank_lz && (idx_q != '0) && (upper == 32'd0);

        seg_d = (lz_blank ? '0 : dec_seg) ^ {SEG_WIDTH{ACTIVE_LOW}};
        an_d  = (DIGITS'(1) << idx_q) ^ {DIGITS{ACTIVE_LOW}};
        dp_d  = dp_mask[idx_q] ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shown_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            seg_q   <= {SEG_WIDTH{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
            an_q    <= {DIGITS{ACTIVE_LOW}};
        end else begin
            shown_q <= shown_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign shown = shown_q;

endmodule
